// File: rtl/register_file_pkg.sv
// Shared MIPS register-file constants and types, also used by the
// write-register select mux and the control unit.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/register_file_if.sv
// Write-back and decode-stage read bundle of the register file.
// The pipeline side is master; the register file is slave.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic              Reg_write;
    logic [ADDR_W-1:0] Write_reg;
    logic [DATA_W-1:0] Write_data;
    logic [ADDR_W-1:0] Read_reg_1;
    logic [ADDR_W-1:0] Read_reg_2;
    logic [DATA_W-1:0] Read_data_1;
    logic [DATA_W-1:0] Read_data_2;

    modport master (
        output Reg_write,
        output Write_reg,
        output Write_data,
        output Read_reg_1,
        output Read_reg_2,
        input  Read_data_1,
        input  Read_data_2
    );

    modport slave (
        input  Reg_write,
        input  Write_reg,
        input  Write_data,
        input  Read_reg_1,
        input  Read_reg_2,
        output Read_data_1,
        output Read_data_2
    );

endinterface

// File: rtl/register_file_write_addr_decoder.sv
// Turns the write-back destination address into a one-hot write strobe.
// $0 never gets a strobe; with Reg_write low the strobe is all zero even if Write_reg is X.
module write_addr_decoder #(
    parameter int ADDR_W = 5
) (
    input  logic                   Reg_write_i,
    input  logic [ADDR_W-1:0]      Write_reg_i,
    output logic [(1<<ADDR_W)-1:0] wr_strobe_o
);

    localparam int NUM_REGS = 1 << ADDR_W;

    always_comb begin
        wr_strobe_o = '0;
        if (Reg_write_i) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                wr_strobe_o[i] = (Write_reg_i == ADDR_W'(i));
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS general-purpose register file: one synchronous write port,
// two asynchronous read ports with optional write-to-read bypass.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    register_file_if.slave rf
);

    import mips_pkg::*;

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [NUM_REGS-1:0] wr_strobe;
    logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0]   regs_d [1:NUM_REGS-1];
    logic                bypass_en;
    logic [DATA_W-1:0]   rd_data_1;
    logic [DATA_W-1:0]   rd_data_2;

    write_addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_write_addr_decoder (
        .Reg_write_i (rf.Reg_write),
        .Write_reg_i (rf.Write_reg),
        .wr_strobe_o (wr_strobe)
    );

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_strobe[i]) begin
                regs_d[i] = rf.Write_data;
            end
        end
    end

    // Reset wins over a same-edge write; $0 has no storage at all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // The forwarded value is not a real write while reset is held, so no bypass then.
    assign bypass_en = BYPASS && rst_n && rf.Reg_write;

    always_comb begin
        if (rf.Read_reg_1 == REG_ZERO) begin
            rd_data_1 = '0;
        end else if (bypass_en && (rf.Write_reg == rf.Read_reg_1)) begin
            rd_data_1 = rf.Write_data;
        end else begin
            rd_data_1 = regs_q[rf.Read_reg_1];
        end
    end

    always_comb begin
        if (rf.Read_reg_2 == REG_ZERO) begin
            rd_data_2 = '0;
        end else if (bypass_en && (rf.Write_reg == rf.Read_reg_2)) begin
            rd_data_2 = rf.Write_data;
        end else begin
            rd_data_2 = regs_q[rf.Read_reg_2];
        end
    end

    assign rf.Read_data_1 = rd_data_1;
    assign rf.Read_data_2 = rd_data_2;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a BYPASS=1 and a BYPASS=0 instance share
// one stimulus stream; expected reads are queued and then checked.
module tb_register_file;

    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    register_file_if #(.DATA_W(32), .ADDR_W(5)) if_b1 ();
    register_file_if #(.DATA_W(32), .ADDR_W(5)) if_b0 ();

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_b1 (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (if_b1.slave)
    );

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_b0 (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (if_b0.slave)
    );

    typedef struct {
        string     tag;
        bit        which;   // 1 = BYPASS=1 instance, 0 = BYPASS=0 instance
        bit        port;    // 0 = read port 1, 1 = read port 2
        reg_data_t exp;
    } exp_t;

    exp_t sb[$];
    int   n_total  = 0;
    int   n_passed = 0;
    int   n_failed = 0;

    task automatic set_wr(input logic we, input reg_addr_t a, input reg_data_t d);
        if_b1.Reg_write = we;  if_b1.Write_reg = a;  if_b1.Write_data = d;
        if_b0.Reg_write = we;  if_b0.Write_reg = a;  if_b0.Write_data = d;
    endtask

    task automatic set_rd(input reg_addr_t a1, input reg_addr_t a2);
        if_b1.Read_reg_1 = a1;  if_b1.Read_reg_2 = a2;
        if_b0.Read_reg_1 = a1;  if_b0.Read_reg_2 = a2;
    endtask

    // Inputs only ever change on the falling edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic push(input string tag, input bit which, input bit port, input reg_data_t e);
        exp_t x;
        x.tag = tag;  x.which = which;  x.port = port;  x.exp = e;
        sb.push_back(x);
    endtask

    // Same expectation on both instances and both ports.
    task automatic push_all(input string tag, input reg_data_t e1, input reg_data_t e2);
        push(tag, 1'b1, 1'b0, e1);  push(tag, 1'b1, 1'b1, e2);
        push(tag, 1'b0, 1'b0, e1);  push(tag, 1'b0, 1'b1, e2);
    endtask

    task automatic drain();
        exp_t      x;
        reg_data_t obs;
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.which) obs = x.port ? if_b1.Read_data_2 : if_b1.Read_data_1;
            else         obs = x.port ? if_b0.Read_data_2 : if_b0.Read_data_1;
            n_total++;
            assert (obs === x.exp) n_passed++;
            else begin
                n_failed++;
                $error("FAIL %s (bypass=%0d port=%0d): observed %h expected %h",
                       x.tag, x.which, x.port + 1, obs, x.exp);
            end
        end
    endtask

    initial begin
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd0);
        @(negedge clk);

        // Preload every register with all ones.
        for (int i = 1; i < 32; i++) begin
            set_wr(1'b1, reg_addr_t'(i), 32'hFFFF_FFFF);
            tick(1);
        end
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd17, REG_RA);
        push_all("preload", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        // One reset edge clears everything.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            set_rd(reg_addr_t'(a), reg_addr_t'(31 - a));
            push_all("reset_clear", 32'h0, 32'h0);
            drain();
        end

        // Basic write then read, neighbour untouched.
        set_wr(1'b1, 5'd8, 32'h1234_5678);
        tick(1);
        set_wr(1'b0, 5'd8, 32'h0);
        set_rd(5'd8, 5'd9);
        push_all("basic_write", 32'h1234_5678, 32'h0);
        drain();

        // Writes to $0 are dropped and never bypassed.
        set_wr(1'b1, REG_ZERO, 32'hDEAD_BEEF);
        set_rd(REG_ZERO, REG_ZERO);
        push_all("zero_same_cycle", 32'h0, 32'h0);
        drain();
        tick(1);
        set_wr(1'b0, 5'd0, 32'h0);
        push_all("zero_after_edge", 32'h0, 32'h0);
        drain();

        // Bypass on $31, same address on both ports.
        set_wr(1'b1, REG_RA, 32'h0000_0004);
        tick(1);
        set_wr(1'b1, REG_RA, 32'h0040_0020);
        set_rd(REG_RA, REG_RA);
        push("bypass_on", 1'b1, 1'b0, 32'h0040_0020);
        push("bypass_on", 1'b1, 1'b1, 32'h0040_0020);
        push("bypass_off", 1'b0, 1'b0, 32'h0000_0004);
        push("bypass_off", 1'b0, 1'b1, 32'h0000_0004);
        drain();
        tick(1);
        set_wr(1'b0, 5'd0, 32'h0);
        push_all("ra_after_edge", 32'h0040_0020, 32'h0040_0020);
        drain();

        // Reset collides with a write; bypass must be off while reset is low.
        rst_n = 1'b0;
        set_wr(1'b1, 5'd5, 32'hAAAA_5555);
        set_rd(5'd5, 5'd5);
        push_all("rst_wr_before", 32'h0, 32'h0);
        drain();
        tick(1);
        push_all("rst_wr_held", 32'h0, 32'h0);
        drain();
        rst_n = 1'b1;
        set_wr(1'b0, 5'd5, 32'h0);
        set_rd(5'd5, REG_RA);
        push_all("rst_discard", 32'h0, 32'h0);
        drain();
        set_rd(5'd8, 5'd5);
        push_all("rst_discard_r8", 32'h0, 32'h0);
        drain();

        // Write-enable gating over several edges, plus X address with Reg_write low.
        set_wr(1'b1, 5'd3, 32'h0000_0011);
        tick(1);
        set_wr(1'b1, 5'd4, 32'h0000_0022);
        tick(1);
        set_wr(1'b0, 5'd3, 32'h0000_0099);
        tick(3);
        set_rd(5'd3, 5'd4);
        push_all("we_gating", 32'h0000_0011, 32'h0000_0022);
        drain();
        set_wr(1'b0, 'x, 32'hFFFF_FFFF);
        tick(2);
        push_all("x_addr_gated", 32'h0000_0011, 32'h0000_0022);
        drain();

        // Independent ports: bypass hits port 1 only.
        set_wr(1'b1, 5'd4, 32'h0000_0055);
        set_rd(5'd4, 5'd3);
        push("port_indep", 1'b1, 1'b0, 32'h0000_0055);
        push("port_indep", 1'b1, 1'b1, 32'h0000_0011);
        push("port_indep", 1'b0, 1'b0, 32'h0000_0022);
        push("port_indep", 1'b0, 1'b1, 32'h0000_0011);
        drain();
        tick(1);
        set_wr(1'b0, 5'd0, 32'h0);
        push_all("port_indep_after", 32'h0000_0055, 32'h0000_0011);
        drain();

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Consumes the 5-bit destination address produced by the write-register select mux (rt / rd / $31).
- Decodes that address to a one-hot write strobe and stores write-back data on the clock edge.
- Provides two asynchronous read ports to the decode stage, with optional same-cycle write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W = 32.
- BYPASS, 1, 1 = a read of the register being written this cycle returns Write_data; 0 = it returns the old stored value.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset.
- Reg_write  input  1  write enable from control, valid in the write-back cycle.
- Write_reg  input  ADDR_W  destination register address, from the write-register select mux.
- Write_data  input  DATA_W  write-back data.
- Read_reg_1  input  ADDR_W  read port 1 address (rs).
- Read_reg_2  input  ADDR_W  read port 2 address (rt).
- Read_data_1  output  DATA_W  read port 1 data.
- Read_data_2  output  DATA_W  read port 2 data.

Behaviour:
- Storage: 32 registers of DATA_W bits. Register 0 has no storage and always reads 0.
- Reset:
  - On a rising clk edge with rst_n = 0, all 31 registers clear to 0x00000000.
  - Reset dominates a simultaneous Reg_write.
  - While rst_n = 0, the bypass path is disabled.
  - Read outputs are combinational, so after the first reset edge both read ports return 0 for every address.
  - Reset asserted mid-program discards all register contents. No partial state is retained.
- Write decode:
  - Write_reg is decoded to a 32-bit one-hot strobe, gated by Reg_write.
  - Bit 0 of the strobe is forced to 0.
- Write timing:
  - On a rising clk edge with rst_n = 1, Reg_write = 1 and Write_reg != 0, register[Write_reg] <= Write_data.
  - Write latency is one edge: the new value is visible from stored state from the next cycle on.
  - A write to $0 is silently dropped.
  - Reg_write = 0 leaves all registers unchanged, whatever Write_reg and Write_data are.
- Read:
  - Purely combinational, zero-cycle latency from address to data.
  - Read_data_n = 0 if Read_reg_n = 0.
  - Otherwise, if BYPASS = 1, rst_n = 1, Reg_write = 1 and Write_reg = Read_reg_n, then Read_data_n = Write_data.
  - Otherwise, Read_data_n = register[Read_reg_n].
- Both read ports are independent. The same address on both ports returns the same value, including when bypass is active.
- Width rules: no sign or zero extension inside the block. All data is DATA_W wide.
- X-safety:
  - Out-of-range addresses cannot occur at ADDR_W = 5.
  - An X on Write_reg while Reg_write = 0 must not corrupt any register.

Decomposition:
- Package mips_pkg:
  - DATA_W and ADDR_W constants.
  - REG_ZERO = 5'd0 and REG_RA = 5'd31, shared with the write-register select mux and control.
  - A reg_addr_t typedef of ADDR_W bits.
- Sub-module write_addr_decoder:
  - Inputs: Write_reg and Reg_write.
  - Output: a 32-bit one-hot write strobe with bit 0 forced to 0.
  - Purely combinational.
  - Instantiated once inside register_file.

Test Plan:
- Reset clear: preload registers 1..31 with 0xFFFFFFFF, then hold rst_n = 0 for one edge -> Read_data_1/2 = 0x00000000 for all 32 addresses.
- Basic write/read: Reg_write = 1, Write_reg = 5'd8, Write_data = 0x12345678, one edge; then Reg_write = 0 and Read_reg_1 = 8 -> Read_data_1 = 0x12345678, and register 9 is still 0.
- $0 protection: write 0xDEADBEEF to Write_reg = 0 -> Read_data_1 at address 0 = 0 both in the same cycle and after the edge, with bypass not taken.
- Bypass:
  - Setup: register 31 holds 0x00000004; then drive Reg_write = 1, Write_reg = 31, Write_data = 0x00400020, Read_reg_2 = 31.
  - BYPASS = 1 -> Read_data_2 = 0x00400020 before the edge.
  - BYPASS = 0 -> Read_data_2 = 0x00000004 before the edge and 0x00400020 after it.
- Reset versus write collision: rst_n = 0 with Reg_write = 1, Write_reg = 5, Write_data = 0xAAAA5555 on the same edge -> register 5 = 0 after the edge, and Read_data_1 at address 5 = 0 while rst_n is low.
- Write-enable gating and dual-port read:
  - Setup: register 3 = 0x11, register 4 = 0x22.
  - Reg_write = 0, Write_reg = 3, Write_data = 0x99 for 3 edges -> register 3 stays 0x11.
  - Read_reg_1 = 3, Read_reg_2 = 4 -> 0x11 and 0x22.
